// File: rtl/or_evt_pkg.sv
// Shared definitions for the OR-stage event capture block:
// debounce FSM state encoding and the debounce counter width.
package or_evt_pkg;

  // Debounce FSM states; the encoding is fixed so other tools can decode it.
  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_QUAL_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_QUAL_L = 2'd3
  } dbc_state_t;

  // Width of the debounce counter; covers DB_CYCLES up to 255.
  localparam int DBC_W = 8;

endpackage

// File: rtl/or_event_capture_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages reset to 0 so a line that is already high is seen as a fresh rise.
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/or_event_capture.sv
// Captures qualified rising edges of the OR-stage output line.
// The line is synchronized, debounced into a clean level, and each
// qualified rise is presented as a held event with valid/ack handshake,
// a saturating event count and a sticky lost-event flag.
module or_event_capture
  import or_evt_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             any_in,
  input  logic             evt_ack,
  input  logic             clr,
  output logic             level,
  output logic             evt_valid,
  output logic             evt_lost,
  output logic [CNT_W-1:0] evt_count
);

  // Last qualification count before a level change is accepted.
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             w_s2;
  logic             w_rise;
  dbc_state_t       r_state;
  logic [DBC_W-1:0] r_dbc;
  logic             r_level;
  logic             r_valid;
  logic             r_lost;
  logic [CNT_W-1:0] r_count;

  bit_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (any_in),
    .o_q   (w_s2)
  );

  // A rise fires on the edge where the high qualification completes; the
  // handshake and counter react on that same edge so they line up with level.
  assign w_rise = (r_state == ST_QUAL_H) && w_s2 && (r_dbc == DBC_LAST);

  // Debounce FSM: a level change needs DB_CYCLES consecutive agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_dbc   <= '0;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        ST_LOW: begin
          if (w_s2) begin
            r_state <= ST_QUAL_H;
            r_dbc   <= DBC_W'(1);
          end
        end
        ST_QUAL_H: begin
          if (!w_s2) begin
            r_state <= ST_LOW;
          end else if (r_dbc == DBC_LAST) begin
            r_state <= ST_HIGH;
            r_level <= 1'b1;
          end else begin
            r_dbc <= r_dbc + DBC_W'(1);
          end
        end
        ST_HIGH: begin
          if (!w_s2) begin
            r_state <= ST_QUAL_L;
            r_dbc   <= DBC_W'(1);
          end
        end
        ST_QUAL_L: begin
          if (w_s2) begin
            r_state <= ST_HIGH;
          end else if (r_dbc == DBC_LAST) begin
            r_state <= ST_LOW;
            r_level <= 1'b0;
          end else begin
            r_dbc <= r_dbc + DBC_W'(1);
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_dbc   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  // Event handshake: a rise wins over a simultaneous ack so the new event is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (w_rise) begin
      r_valid <= 1'b1;
    end else if (evt_ack) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky lost flag: a rise arriving over an unacknowledged event; clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lost <= 1'b0;
    end else if (clr) begin
      r_lost <= 1'b0;
    end else if (w_rise && r_valid && !evt_ack) begin
      r_lost <= 1'b1;
    end
  end

  // Saturating count of qualified rises; clr beats a simultaneous rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_rise && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign level     = r_level;
  assign evt_valid = r_valid;
  assign evt_lost  = r_lost;
  assign evt_count = r_count;

endmodule

// File: tb/tb_or_event_capture.sv
// Bench for or_event_capture: two instances (CNT_W=8 and CNT_W=3) share
// stimulus; a window-based behavioural model predicts every output.
module tb_or_event_capture;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       any_in = 1'b0;
  logic       evt_ack = 1'b0;
  logic       clr = 1'b0;

  logic       level_a, valid_a, lost_a;
  logic [7:0] count_a;
  logic       level_b, valid_b, lost_b;
  logic [2:0] count_b;

  or_event_capture #(.DB_CYCLES(DB), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .any_in(any_in), .evt_ack(evt_ack), .clr(clr),
    .level(level_a), .evt_valid(valid_a), .evt_lost(lost_a), .evt_count(count_a)
  );

  or_event_capture #(.DB_CYCLES(DB), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .any_in(any_in), .evt_ack(evt_ack), .clr(clr),
    .level(level_b), .evt_valid(valid_b), .evt_lost(lost_b), .evt_count(count_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The level flips once the last DB synchronized samples all disagree with it.
  bit         m_s1, m_s2;
  bit [255:0] m_hist;
  bit         m_level, m_valid, m_lost;
  int         m_raw;   // rises since last clr/reset, unbounded

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_hist = '0;
    m_level = 0; m_valid = 0; m_lost = 0; m_raw = 0;
  endtask

  task automatic model_step();
    bit all_hi, all_lo, rise;
    m_hist = {m_hist[254:0], m_s2};
    all_hi = 1; all_lo = 1;
    for (int i = 0; i < DB; i++) begin
      if (m_hist[i]) all_lo = 0;
      else           all_hi = 0;
    end
    rise = !m_level && all_hi;
    if (rise) m_level = 1;
    else if (m_level && all_lo) m_level = 0;
    if (rise) begin
      if (m_valid && !evt_ack) m_lost = 1;
      m_valid = 1;
    end else if (evt_ack) begin
      m_valid = 0;
    end
    if (clr) begin
      m_lost = 0;
      m_raw  = 0;
    end else if (rise) begin
      m_raw++;
    end
    m_s2 = m_s1;
    m_s1 = any_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare both instances against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level_a", level_a, m_level);
      chk("valid_a", valid_a, m_valid);
      chk("lost_a",  lost_a,  m_lost);
      chk("count_a", count_a, sat(m_raw, 255));
      chk("level_b", level_b, m_level);
      chk("valid_b", valid_b, m_valid);
      chk("lost_b",  lost_b,  m_lost);
      chk("count_b", count_b, sat(m_raw, 7));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int h);
    any_in = 1'b1;
    tick(h);
    any_in = 1'b0;
    tick(8);
  endtask

  task automatic ack_once();
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
  endtask

  int run_left;

  initial begin
    // Reset state and first-rise latency
    do_reset();
    chk("rst_level", level_a, 0);
    chk("rst_count", count_a, 0);
    any_in = 1'b1;
    tick(5);
    chk("s1_level_e5", level_a, 0);
    chk("s1_valid_e5", valid_a, 0);
    tick(1);
    chk("s1_level_e6", level_a, 1);
    chk("s1_valid_e6", valid_a, 1);
    chk("s1_count", count_a, 1);
    tick(2);
    any_in = 1'b0;
    tick(8);
    chk("s1_level_fall", level_a, 0);

    // Short pulse must not qualify
    do_reset();
    any_in = 1'b1;
    tick(3);
    any_in = 1'b0;
    tick(10);
    chk("s2_level", level_a, 0);
    chk("s2_valid", valid_a, 0);
    chk("s2_count", count_a, 0);

    // Two rises without ack -> lost; then ack and clr
    do_reset();
    pulse(8);
    pulse(8);
    chk("s3_count", count_a, 2);
    chk("s3_lost", lost_a, 1);
    chk("s3_valid", valid_a, 1);
    ack_once();
    chk("s3_valid_ack", valid_a, 0);
    chk("s3_lost_hold", lost_a, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("s3_count_clr", count_a, 0);
    chk("s3_lost_clr", lost_a, 0);

    // Ack on the same edge as a second rise
    do_reset();
    pulse(8);
    chk("s4_valid_first", valid_a, 1);
    any_in = 1'b1;
    tick(5);
    evt_ack = 1'b1;
    tick(1);
    evt_ack = 1'b0;
    chk("s4_valid", valid_a, 1);
    chk("s4_lost", lost_a, 0);
    chk("s4_count", count_a, 2);
    any_in = 1'b0;
    tick(8);
    ack_once();

    // Saturation of the 3-bit counter
    do_reset();
    repeat (9) begin
      pulse(8);
      ack_once();
    end
    chk("s5_count_b", count_b, 7);
    chk("s5_count_a", count_a, 9);
    chk("s5_lost_b", lost_b, 0);

    // Asynchronous reset while qualifying a rise
    do_reset();
    pulse(8);
    chk("s6_valid_pre", valid_a, 1);
    any_in = 1'b1;
    tick(4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_level_rst", level_a, 0);
    chk("s6_valid_rst", valid_a, 0);
    chk("s6_count_rst", count_a, 0);
    chk("s6_lost_rst", lost_a, 0);
    tick(1);
    any_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("s6_valid_post", valid_a, 0);
    chk("s6_level_post", level_a, 0);
    chk("s6_count_post", count_a, 0);

    // Randomized traffic, checked every cycle by the model
    do_reset();
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if (run_left == 0) begin
        any_in   = ~any_in;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                               : $urandom_range(4, 14);
      end
      run_left--;
      evt_ack = ($urandom_range(0, 5) == 0);
      clr     = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    evt_ack = 1'b0;
    clr     = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
